// File: rtl/npc_bpred.sv
// Predicting next-PC unit: owns the fetch PC, looks up a direct-mapped BTB with
// 2-bit counters, redirects after the delay slot and repairs/trains from E.
module npc_bpred #(
  parameter int          ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_stall,
  output logic [31:0] F_PC,
  output logic        F_predTaken,
  output logic [31:0] F_predTarget,
  output logic        F_flush,
  input  logic        E_valid,
  input  logic        E_isCtrl,
  input  logic        E_taken,
  input  logic [31:0] E_target,
  input  logic [31:0] E_PC,
  input  logic        E_predTaken,
  input  logic [31:0] E_predTarget,
  output logic        E_mispredict,
  output logic [31:0] E_PC8
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = 30 - IDX;

  logic          btb_valid  [ENTRIES];
  logic [TW-1:0] btb_tag    [ENTRIES];
  logic [31:0]   btb_target [ENTRIES];
  logic [1:0]    btb_ctr    [ENTRIES];

  logic          pend_v;
  logic [31:0]   pend_tgt;

  logic [IDX-1:0] f_idx;
  logic [IDX-1:0] e_idx;
  logic           f_hit;
  logic           e_hit;
  logic [31:0]    correct_pc;
  logic [31:0]    next_pc;

  assign f_idx = F_PC[IDX+1:2];
  assign e_idx = E_PC[IDX+1:2];
  assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == F_PC[31:IDX+2]);
  assign e_hit = btb_valid[e_idx] && (btb_tag[e_idx] == E_PC[31:IDX+2]);

  assign F_predTaken  = f_hit && btb_ctr[f_idx][1];
  assign F_predTarget = f_hit ? btb_target[f_idx] : F_PC + 32'd4;

  // A non-control instruction predicted taken is a stale BTB alias.
  assign E_mispredict = E_valid &&
                        ((E_isCtrl && ((E_taken != E_predTaken) ||
                                       (E_taken && (E_target != E_predTarget)))) ||
                         (!E_isCtrl && E_predTaken));
  assign E_PC8      = E_PC + 32'd8;
  assign correct_pc = (E_taken && E_isCtrl) ? E_target : E_PC8;
  assign F_flush    = E_mispredict && !F_stall;

  always_comb begin
    next_pc = F_PC + 32'd4;
    if (E_mispredict)  next_pc = correct_pc;
    else if (F_stall)  next_pc = F_PC;
    else if (pend_v)   next_pc = pend_tgt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      F_PC     <= RESET_PC;
      pend_v   <= 1'b0;
      pend_tgt <= RESET_PC;
    end else begin
      F_PC <= next_pc;
      if (E_mispredict) begin
        pend_v <= 1'b0;
      end else if (!F_stall) begin
        // Consumes any pending redirect and arms a new one in the same step.
        pend_v   <= F_predTaken;
        pend_tgt <= F_predTarget;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'b01;
      end
    end else if (E_valid && E_isCtrl) begin
      if (e_hit) begin
        if (E_taken) begin
          if (btb_ctr[e_idx] != 2'b11) btb_ctr[e_idx] <= btb_ctr[e_idx] + 2'd1;
          btb_target[e_idx] <= E_target;
        end else if (btb_ctr[e_idx] != 2'b00) begin
          btb_ctr[e_idx] <= btb_ctr[e_idx] - 2'd1;
        end
      end else if (E_taken) begin
        btb_valid[e_idx]  <= 1'b1;
        btb_tag[e_idx]    <= E_PC[31:IDX+2];
        btb_target[e_idx] <= E_target;
        btb_ctr[e_idx]    <= 2'b10;
      end
    end else if (E_valid && E_predTaken && e_hit) begin
      btb_valid[e_idx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_npc_bpred.sv
// Directed bench for npc_bpred: a 16-entry instance for the main scenarios and a
// 4-entry instance sharing the same stimulus for the aliasing scenarios.
module tb_npc_bpred;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        F_stall = 1'b0;
  logic        E_valid, E_isCtrl, E_taken, E_predTaken;
  logic [31:0] E_target, E_PC, E_predTarget;

  logic [31:0] F_PC, F_predTarget, E_PC8;
  logic        F_predTaken, F_flush, E_mispredict;
  logic [31:0] f_pc4, f_pred_target4, e_pc8_4;
  logic        f_pred_taken4, f_flush4, e_mispredict4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  npc_bpred #(.ENTRIES(16), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .F_stall(F_stall),
    .F_PC(F_PC), .F_predTaken(F_predTaken), .F_predTarget(F_predTarget), .F_flush(F_flush),
    .E_valid(E_valid), .E_isCtrl(E_isCtrl), .E_taken(E_taken), .E_target(E_target),
    .E_PC(E_PC), .E_predTaken(E_predTaken), .E_predTarget(E_predTarget),
    .E_mispredict(E_mispredict), .E_PC8(E_PC8)
  );

  npc_bpred #(.ENTRIES(4), .RESET_PC(32'h0000_3000)) dut4 (
    .clk(clk), .reset(reset), .F_stall(F_stall),
    .F_PC(f_pc4), .F_predTaken(f_pred_taken4), .F_predTarget(f_pred_target4), .F_flush(f_flush4),
    .E_valid(E_valid), .E_isCtrl(E_isCtrl), .E_taken(E_taken), .E_target(E_target),
    .E_PC(E_PC), .E_predTaken(E_predTaken), .E_predTarget(E_predTarget),
    .E_mispredict(e_mispredict4), .E_PC8(e_pc8_4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic e_idle();
    E_valid = 1'b0; E_isCtrl = 1'b0; E_taken = 1'b0; E_predTaken = 1'b0;
    E_target = '0; E_PC = '0; E_predTarget = '0;
  endtask

  task automatic drive_e(input logic [31:0] pc, input logic ctrl, input logic taken,
                         input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
    E_valid = 1'b1; E_isCtrl = ctrl; E_taken = taken; E_target = tgt;
    E_PC = pc; E_predTaken = ptaken; E_predTarget = ptgt;
    #1;
  endtask

  // Forces fetch to pc via a predicted-taken, actually-not-taken branch at pc-8
  // whose BTB slot is never allocated, so no training side effects.
  task automatic redirect(input logic [31:0] pc);
    drive_e(pc - 32'd8, 1'b1, 1'b0, 32'h0, 1'b1, pc - 32'd4);
    tick();
    e_idle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    e_idle();
    reset = 1'b0;
    tick(); tick();
    checks++; if (F_PC !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h exp %h", F_PC, 32'h3000); end
    checks++; if (F_predTaken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %b exp 0", F_predTaken); end
    checks++; if (F_predTarget !== 32'h3004) begin errors++; $display("FAIL reset_pred_target got %h exp %h", F_predTarget, 32'h3004); end
    checks++; if (F_flush !== 1'b0 || E_mispredict !== 1'b0) begin errors++; $display("FAIL reset_flush_misp got %b%b exp 00", F_flush, E_mispredict); end
    checks++; if (f_pc4 !== 32'h3000) begin errors++; $display("FAIL reset_pc4 got %h exp %h", f_pc4, 32'h3000); end
    reset = 1'b1;
    #1;
    checks++; if (F_PC !== 32'h3000) begin errors++; $display("FAIL release_pc0 got %h exp %h", F_PC, 32'h3000); end
    tick();
    checks++; if (F_PC !== 32'h3004 || F_predTaken !== 1'b0) begin errors++; $display("FAIL release_pc1 got %h/%b exp 3004/0", F_PC, F_predTaken); end
    tick();
    checks++; if (F_PC !== 32'h3008 || F_predTaken !== 1'b0) begin errors++; $display("FAIL release_pc2 got %h/%b exp 3008/0", F_PC, F_predTaken); end
  endtask

  task automatic test_cold_beq();
    do_reset();
    tick(); tick();
    checks++; if (F_PC !== 32'h3008) begin errors++; $display("FAIL cold_cycle2_pc got %h exp %h", F_PC, 32'h3008); end
    drive_e(32'h3000, 1'b1, 1'b1, 32'h3040, 1'b0, 32'h3004);
    checks++; if (E_mispredict !== 1'b1 || F_flush !== 1'b1) begin errors++; $display("FAIL cold_misp_flush got %b%b exp 11", E_mispredict, F_flush); end
    checks++; if (E_PC8 !== 32'h3008) begin errors++; $display("FAIL cold_pc8 got %h exp %h", E_PC8, 32'h3008); end
    tick();
    e_idle();
    checks++; if (F_PC !== 32'h3040) begin errors++; $display("FAIL cold_redirect_pc got %h exp %h", F_PC, 32'h3040); end
    redirect(32'h3000);
    checks++; if (F_predTaken !== 1'b1 || F_predTarget !== 32'h3040) begin errors++; $display("FAIL cold_alloc got %b/%h exp 1/3040", F_predTaken, F_predTarget); end
  endtask

  task automatic test_warm_loop();
    for (int n = 0; n < 3; n++) begin
      checks++; if (F_predTaken !== 1'b1) begin errors++; $display("FAIL warm_pred_%0d got %b exp 1", n, F_predTaken); end
      tick();
      checks++; if (F_PC !== 32'h3004) begin errors++; $display("FAIL warm_slot_%0d got %h exp %h", n, F_PC, 32'h3004); end
      tick();
      checks++; if (F_PC !== 32'h3040) begin errors++; $display("FAIL warm_tgt_%0d got %h exp %h", n, F_PC, 32'h3040); end
      drive_e(32'h3000, 1'b1, 1'b1, 32'h3040, 1'b1, 32'h3040);
      checks++; if (E_mispredict !== 1'b0) begin errors++; $display("FAIL warm_nomisp_%0d got %b exp 0", n, E_mispredict); end
      tick();
      e_idle();
      checks++; if (F_PC !== 32'h3044) begin errors++; $display("FAIL warm_seq_%0d got %h exp %h", n, F_PC, 32'h3044); end
      redirect(32'h3000);
    end
    tick(); tick();
    drive_e(32'h3000, 1'b1, 1'b0, 32'h3040, 1'b1, 32'h3040);
    checks++; if (E_mispredict !== 1'b1 || F_flush !== 1'b1) begin errors++; $display("FAIL nt_misp got %b%b exp 11", E_mispredict, F_flush); end
    tick();
    e_idle();
    checks++; if (F_PC !== 32'h3008) begin errors++; $display("FAIL nt_redirect got %h exp %h", F_PC, 32'h3008); end
    redirect(32'h3000);
    checks++; if (F_predTaken !== 1'b1) begin errors++; $display("FAIL nt_still_taken got %b exp 1", F_predTaken); end
    tick(); tick();
    drive_e(32'h3000, 1'b1, 1'b0, 32'h3040, 1'b1, 32'h3040);
    tick();
    e_idle();
    redirect(32'h3000);
    checks++; if (F_predTaken !== 1'b0 || F_predTarget !== 32'h3040) begin errors++; $display("FAIL nt_weak got %b/%h exp 0/3040", F_predTaken, F_predTarget); end
  endtask

  task automatic test_jr_target();
    redirect(32'h3100);
    checks++; if (F_predTaken !== 1'b0 || F_predTarget !== 32'h3104) begin errors++; $display("FAIL jr_cold got %b/%h exp 0/3104", F_predTaken, F_predTarget); end
    tick(); tick();
    drive_e(32'h3100, 1'b1, 1'b1, 32'h3200, 1'b0, 32'h3104);
    checks++; if (E_mispredict !== 1'b1) begin errors++; $display("FAIL jr_train_misp got %b exp 1", E_mispredict); end
    tick();
    e_idle();
    checks++; if (F_PC !== 32'h3200) begin errors++; $display("FAIL jr_train_pc got %h exp %h", F_PC, 32'h3200); end
    redirect(32'h3100);
    checks++; if (F_predTaken !== 1'b1 || F_predTarget !== 32'h3200) begin errors++; $display("FAIL jr_trained got %b/%h exp 1/3200", F_predTaken, F_predTarget); end
    tick(); tick();
    checks++; if (F_PC !== 32'h3200) begin errors++; $display("FAIL jr_pred_fetch got %h exp %h", F_PC, 32'h3200); end
    drive_e(32'h3100, 1'b1, 1'b1, 32'h3300, 1'b1, 32'h3200);
    checks++; if (E_mispredict !== 1'b1 || E_PC8 !== 32'h3108) begin errors++; $display("FAIL jr_change got %b/%h exp 1/3108", E_mispredict, E_PC8); end
    tick();
    e_idle();
    checks++; if (F_PC !== 32'h3300) begin errors++; $display("FAIL jr_change_pc got %h exp %h", F_PC, 32'h3300); end
    redirect(32'h3100);
    checks++; if (F_predTarget !== 32'h3300) begin errors++; $display("FAIL jr_retarget got %h exp %h", F_predTarget, 32'h3300); end
  endtask

  task automatic test_stall();
    tick();
    F_stall = 1'b1;
    drive_e(32'h3100, 1'b1, 1'b1, 32'h3400, 1'b1, 32'h3300);
    checks++; if (F_flush !== 1'b0 || E_mispredict !== 1'b1) begin errors++; $display("FAIL stall_flush got %b/%b exp 0/1", F_flush, E_mispredict); end
    tick();
    e_idle();
    F_stall = 1'b0;
    checks++; if (F_PC !== 32'h3400) begin errors++; $display("FAIL stall_redirect got %h exp %h", F_PC, 32'h3400); end
    tick();
    checks++; if (F_PC !== 32'h3404) begin errors++; $display("FAIL stall_pend_clr got %h exp %h", F_PC, 32'h3404); end
    redirect(32'h3100);
    checks++; if (F_predTarget !== 32'h3400) begin errors++; $display("FAIL stall_trained got %h exp %h", F_predTarget, 32'h3400); end
    tick();
    F_stall = 1'b1;
    tick(); tick();
    checks++; if (F_PC !== 32'h3104) begin errors++; $display("FAIL stall_hold got %h exp %h", F_PC, 32'h3104); end
    F_stall = 1'b0;
    tick();
    checks++; if (F_PC !== 32'h3400) begin errors++; $display("FAIL stall_pend_kept got %h exp %h", F_PC, 32'h3400); end
  endtask

  task automatic test_reset_mid();
    redirect(32'h3100);
    tick();
    reset = 1'b0;
    tick();
    checks++; if (F_PC !== 32'h3000) begin errors++; $display("FAIL mid_reset_pc got %h exp %h", F_PC, 32'h3000); end
    reset = 1'b1;
    tick();
    checks++; if (F_PC !== 32'h3004) begin errors++; $display("FAIL mid_pend_drop got %h exp %h", F_PC, 32'h3004); end
    redirect(32'h3100);
    checks++; if (F_predTaken !== 1'b0) begin errors++; $display("FAIL mid_btb_clr got %b exp 0", F_predTaken); end
  endtask

  task automatic test_aliasing();
    logic [31:0] pc, tgt;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      pc  = (k % 2 == 1) ? 32'h3010 : 32'h3000;
      tgt = pc + 32'h80;
      redirect(pc);
      checks++; if (f_pred_taken4 !== 1'b0 || f_pred_target4 !== pc + 32'd4) begin errors++; $display("FAIL alias_pred_%0d got %b/%h exp 0/%h", k, f_pred_taken4, f_pred_target4, pc + 32'd4); end
      tick(); tick();
      drive_e(pc, 1'b1, 1'b1, tgt, 1'b0, pc + 32'd4);
      checks++; if (e_mispredict4 !== 1'b1) begin errors++; $display("FAIL alias_misp_%0d got %b exp 1", k, e_mispredict4); end
      tick();
      e_idle();
      checks++; if (f_pc4 !== tgt) begin errors++; $display("FAIL alias_pc_%0d got %h exp %h", k, f_pc4, tgt); end
    end
    redirect(32'h3010);
    checks++; if (f_pred_taken4 !== 1'b1) begin errors++; $display("FAIL alias_b_live got %b exp 1", f_pred_taken4); end
    drive_e(32'h3010, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3090);
    checks++; if (e_mispredict4 !== 1'b1 || f_flush4 !== 1'b1 || e_pc8_4 !== 32'h3018) begin errors++; $display("FAIL stale_misp got %b%b/%h exp 11/3018", e_mispredict4, f_flush4, e_pc8_4); end
    tick();
    e_idle();
    checks++; if (f_pc4 !== 32'h3018) begin errors++; $display("FAIL stale_pc got %h exp %h", f_pc4, 32'h3018); end
    redirect(32'h3010);
    checks++; if (f_pred_taken4 !== 1'b0) begin errors++; $display("FAIL stale_clear got %b exp 0", f_pred_taken4); end
  endtask

  task automatic test_misc();
    drive_e(32'h3010, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checks++; if (E_mispredict !== 1'b0) begin errors++; $display("FAIL nonctrl_ok got %b exp 0", E_mispredict); end
    drive_e(32'h3000, 1'b1, 1'b1, 32'h3040, 1'b0, 32'h3004);
    E_valid = 1'b0;
    #1;
    checks++; if (E_mispredict !== 1'b0 || F_flush !== 1'b0) begin errors++; $display("FAIL bubble got %b%b exp 00", E_mispredict, F_flush); end
    E_PC = 32'hFFFF_FFFC;
    #1;
    checks++; if (E_PC8 !== 32'h0000_0004) begin errors++; $display("FAIL pc8_wrap got %h exp %h", E_PC8, 32'h4); end
    e_idle();
  endtask

  initial begin
    e_idle();
    test_reset();
    test_cold_beq();
    test_warm_loop();
    test_jr_target();
    test_stall();
    test_reset_mid();
    test_aliasing();
    test_misc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/npc_bpred.md
# npc_bpred

Predicting next-PC unit for the pipelined MIPS core, successor to the D-stage combinational next-PC logic. Owns the F-stage PC register, looks up a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters on the fetch PC, and redirects fetch after the delay slot. Branch/jump resolution moves to the E stage. The block compares the outcome with the prediction carried down the pipe, repairs the PC, flushes the wrong-path fetch and trains the BTB.

## Interface
- `ENTRIES`, 16: BTB entries; power of two, 2..256. `IDX = log2(ENTRIES)`.
- `RESET_PC`, 32'h0000_3000: F_PC value after reset.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-low reset.
- `F_stall` input 1: hazard unit freezes the PC and F/D registers.
- `F_PC` output 32: current fetch address.
- `F_predTaken` output 1: prediction for the instruction at F_PC; piped to E.
- `F_predTarget` output 32: predicted target; piped to E.
- `F_flush` output 1: kill the instruction in F so it does not enter D.
- `E_valid` input 1: E holds a real instruction, not a bubble.
- `E_isCtrl` input 1: E instruction is beq/bne/bslt/jal/jr.
- `E_taken` input 1: actual outcome; 1 for all jumps.
- `E_target` input 32: actual target for branch, jal or jr.
- `E_PC` input 32: PC of the E instruction.
- `E_predTaken`, `E_predTarget` input 1/32: prediction carried with the E instruction.
- `E_mispredict` output 1: redirect in progress.
- `E_PC8` output 32: E_PC + 8, the jal link value.

## Operation
- BTB entry: valid, tag = PC[31:IDX+2], target[31:0], ctr[1:0]. Index = PC[IDX+1:2].
- Lookup on F_PC, combinational:
  - hit = valid && tag match.
  - F_predTaken = hit && ctr[1].
  - F_predTarget = entry target when hit, else F_PC + 4.
- Pending redirect register (pend_v, pend_tgt) implements the delay slot:
  - Set when F_predTaken && !F_stall && !E_mispredict; pend_tgt = F_predTarget.
  - Consumed on the next non-stalled cycle.
- Mispredict, only when E_valid:
  - (E_isCtrl && (E_taken != E_predTaken || (E_taken && E_target != E_predTarget))), or
  - (!E_isCtrl && E_predTaken), a stale alias.
- Correct PC = E_taken && E_isCtrl ? E_target : E_PC + 8.
- Next-PC priority:
  1. !reset: RESET_PC.
  2. E_mispredict: correct PC.
  3. F_stall: hold.
  4. pend_v: pend_tgt.
  5. Otherwise F_PC + 4.
- Pending state:
  - pend_v clears on reset, on E_mispredict, and when consumed.
  - pend_v holds while F_stall is asserted.
- F_flush = E_mispredict && !F_stall. Under stall, F/D keeps the delay slot and only the PC is redirected.
- Training, when E_valid && E_isCtrl, independent of F_stall:
  - Hit, taken: ctr saturating +1, target = E_target.
  - Hit, not taken: ctr saturating −1, target unchanged.
  - Miss, taken: allocate with valid = 1, tag, target = E_target, ctr = 2'b10.
  - Miss, not taken: no write.
- When E_valid && !E_isCtrl && E_predTaken: clear that entry's valid bit if its tag matches E_PC.
- All arithmetic is 32-bit modulo 2^32; the PC wraps silently.

## Timing
- Reset (reset == 0 at an edge):
  - F_PC = RESET_PC, pend_v = 0.
  - All BTB valid bits = 0, all ctr = 2'b01.
  - Outputs at reset: F_predTaken = 0, F_predTarget = RESET_PC + 4, F_flush = 0, E_mispredict = 0.
  - Reset mid-operation discards the pending redirect and all training.
- Branch at PC p, predicted taken with target t:
  - Cycle 0: fetch p.
  - Cycle 1: fetch p+4 (delay slot).
  - Cycle 2: fetch t; branch resolves in E.
- Mispredict penalty is 1 cycle: F_flush is asserted in the resolve cycle, and the correct PC is fetched in the next cycle.
- BTB writes land at the clock edge. A same-cycle read of the same index returns the old contents.
- E_mispredict, F_flush and E_PC8 are combinational from E inputs and registered state.

## Test plan
- Reset:
  - Hold reset = 0 for 2 cycles, then release → F_PC = 0x3000, then 0x3004, 0x3008.
  - F_predTaken = 0 throughout.
- Cold taken beq:
  - beq at 0x3000, target 0x3040 → cycle 2 fetches 0x3008.
  - E_mispredict = 1 and F_flush = 1; next F_PC = 0x3040.
  - Entry 0 allocated with ctr = 2'b10.
- Warm loop:
  - Run the same beq taken 3 more times → F_predTaken = 1 at 0x3000; fetch order 0x3000, 0x3004, 0x3040.
  - No mispredict; ctr saturates at 2'b11.
  - One not-taken outcome → mispredict, next F_PC = 0x3008, ctr = 2'b10.
  - Still predicts taken next time.
- jr target change:
  - jr at 0x3100 trained to 0x3200, then executes to 0x3300 → mispredict, redirect to 0x3300, entry target = 0x3300.
- Stall collision:
  - F_stall = 1 in the same cycle as E_mispredict → F_flush = 0; F_PC = correct target next cycle; pend_v = 0.
- Aliasing with ENTRIES = 4:
  - Taken branches at 0x3000 and 0x3010 alternate → each one evicts the other and every execution mispredicts.
  - Non-ctrl E with E_predTaken = 1 → redirect to E_PC + 8.
